matmul_apb_master: RTL
======================

Name: matmul_apb_master

Overview:
- APB requester that sits directly upstream of the matmul slave and drives its psel/penable/pwrite/pstrb/pwdata/paddr inputs.
- Accepts register read/write commands from a valid/ready command port and buffers them in a small FIFO.
- Runs each command as a compliant APB setup/access transfer, honouring pready wait states and applying a timeout.
- Returns read data and error status on a valid/ready response port, one response per command, in order.

Parameters:
- DATA_WIDTH, 16, element width; sets strobe width.
- BUS_WIDTH, 64, APB data width.
- ADDR_WIDTH, 32, APB address width.
- CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 64, maximum ACCESS cycles allowed without pready.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO not full
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  BUS_WIDTH  write data
- cmd_strb_i  in  BUS_WIDTH/DATA_WIDTH  write strobes, one per element
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  BUS_WIDTH  captured prdata; 0 for writes and timeouts
- rsp_err_o  out  1  pslverr seen or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- psel_o, penable_o, pwrite_o  out  1  APB control
- pstrb_o  out  BUS_WIDTH/DATA_WIDTH  APB strobe
- pwdata_o  out  BUS_WIDTH  APB write data
- paddr_o  out  ADDR_WIDTH  APB address
- pready_i, pslverr_i  in  1  APB slave status
- prdata_i  in  BUS_WIDTH  APB read data
- busy_o  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (async, while rst_ni = 0):
  - Every output is 0 except cmd_ready_o = 1.
  - FIFO is emptied; FSM returns to IDLE; timeout counter is cleared.
  - A transfer in progress is dropped with no response. psel_o falls asynchronously.
- Command push: happens when cmd_valid_i && cmd_ready_o at a rising edge. cmd_ready_o = !full, registered from FIFO occupancy.
- FIFO push and pop in the same cycle: allowed when full or empty; occupancy is unchanged.
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: if FIFO non-empty, pop the head into the transfer register and go to SETUP.
  - SETUP: drive psel_o = 1, penable_o = 0. Go to ACCESS unconditionally.
  - ACCESS: drive psel_o = 1, penable_o = 1. The timeout counter increments every cycle.
    - If pready_i = 1: capture prdata_i (reads only) and pslverr_i, then go to RESP.
    - Else if the counter reaches TIMEOUT_CYC-1: set rsp_err/rsp_timeout = 1, rdata = 0, then go to RESP.
  - RESP: psel_o and penable_o are 0; rsp_valid_o = 1, and rsp_* is held stable until rsp_ready_i.
    - On acceptance with FIFO non-empty: pop and go directly to SETUP.
    - Otherwise go to IDLE.
- Address, pwrite, pstrb and pwdata are stable from SETUP through the last ACCESS cycle.
- Reads drive pstrb_o = 0 and pwdata_o = 0.
- Latency: a command pushed at edge N into an empty idle block gives psel_o = 1 during cycle N+2. With zero wait states, rsp_valid_o first rises in cycle N+4.
- Back-to-back throughput, zero wait states, rsp_ready_i held 1: one command per 3 cycles.
- pslverr_i sets rsp_err_o = 1 with rsp_timeout_o = 0. Read data is still returned as captured.
- pready_i and pslverr_i are ignored outside ACCESS.

Decomposition:
- matmul_pkg additions:
  - CMD_DEPTH_DEF and APB_TIMEOUT_DEF constants.
  - STRB_WIDTH = BUS_WIDTH/DATA_WIDTH.
  - Packed struct apb_cmd_t {write, addr, wdata, strb}.
  - Enum apb_mst_state_t {IDLE, SETUP, ACCESS, RESP}.
- Sub-module matmul_cmd_fifo:
  - Synchronous FIFO of apb_cmd_t, CMD_DEPTH deep.
  - push/pop/full/empty; pointers are one bit wider than the index to handle wrap-around.
  - Asynchronous active-low reset.
- The top-level module holds the FSM, the timeout counter and the response registers.

Test Plan:
- Write to addr 0x10, wdata 0x0004_0003_0002_0001, strb 4'b1111, pready tied 1 -> SETUP then ACCESS with matching paddr/pwdata; rsp_valid with err=0, rdata=0.
- Read addr 0x20, slave stalls 2 cycles then returns prdata 0xDEAD_BEEF_0000_0001 -> penable held 3 cycles, pstrb=0, rsp_rdata matches, err=0.
- Read with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0, busy_o returns to 0 after acceptance.
- Slave never asserts pready, TIMEOUT_CYC=64 -> exactly 64 ACCESS cycles, psel drops, rsp_err=1, rsp_timeout=1, rdata=0.
- Push 6 commands with rsp_ready_i=0 and CMD_DEPTH=4 -> cmd_ready_o drops after the 4th push is queued behind the active transfer. Releasing rsp_ready gives all responses in order with 3-cycle spacing.
- Assert rst_ni=0 mid-ACCESS -> psel/penable drop in the same cycle; after release cmd_ready_o=1, busy_o=0, and no stale response appears.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and types for the matmul APB requester
package matmul_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int BUS_WIDTH_DEF   = 64;
    localparam int ADDR_WIDTH_DEF  = 32;
    localparam int CMD_DEPTH_DEF   = 4;
    localparam int APB_TIMEOUT_DEF = 64;
    localparam int STRB_WIDTH      = BUS_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [BUS_WIDTH_DEF-1:0]  wdata;
        logic [STRB_WIDTH-1:0]     strb;
    } apb_cmd_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

endpackage

// File: rtl/matmul_cmd_fifo.sv
// matmul_cmd_fifo: command FIFO; pointers carry one extra wrap bit to tell full from empty
module matmul_cmd_fifo
    import matmul_pkg::*;
#(
    parameter int DEPTH = CMD_DEPTH_DEF
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push,
    input  logic     pop,
    input  apb_cmd_t wdata,
    output apb_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    apb_cmd_t       mem [DEPTH];
    logic [AW:0]    wptr, rptr;
    logic           do_push, do_pop;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Push+pop while empty passes the entry straight through and leaves the pointers alone
    assign do_push = push && (empty ? !pop : (!full || pop));
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? wdata : mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i)
        if (do_push) mem[wptr[AW-1:0]] <= wdata;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end

endmodule

// File: rtl/matmul_apb_master.sv
// matmul_apb_master: buffers register commands and runs them as APB transfers with timeout,
// returning one in-order response per command.
module matmul_apb_master
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int CMD_DEPTH   = CMD_DEPTH_DEF,
    parameter int TIMEOUT_CYC = APB_TIMEOUT_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]            cmd_wdata_i,
    input  logic [BUS_WIDTH/DATA_WIDTH-1:0] cmd_strb_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic                            rsp_timeout_o,
    output logic                            psel_o,
    output logic                            penable_o,
    output logic                            pwrite_o,
    output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
    output logic [BUS_WIDTH-1:0]            pwdata_o,
    output logic [ADDR_WIDTH-1:0]           paddr_o,
    input  logic                            pready_i,
    input  logic                            pslverr_i,
    input  logic [BUS_WIDTH-1:0]            prdata_i,
    output logic                            busy_o
);

    localparam int                TW   = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]     TLIM = TW'(TIMEOUT_CYC - 1);

    apb_cmd_t       cmd, head, xfer, load;
    apb_mst_state_t state;
    logic [TW-1:0]  tcnt;
    logic           full, empty, pop;

    assign cmd = '{write: cmd_write_i, addr: cmd_addr_i, wdata: cmd_wdata_i, strb: cmd_strb_i};
    // Reads never expose stale write data or strobes on the bus
    assign load = '{write: head.write, addr: head.addr,
                    wdata: head.write ? head.wdata : '0, strb: head.write ? head.strb : '0};
    assign pop = !empty && (state == IDLE || (state == RESP && rsp_ready_i));

    assign cmd_ready_o = !full;
    assign busy_o      = !empty || state != IDLE;
    assign pwrite_o    = xfer.write;
    assign paddr_o     = xfer.addr;
    assign pwdata_o    = xfer.wdata;
    assign pstrb_o     = xfer.strb;

    matmul_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (cmd_valid_i && !full),
        .pop   (pop),
        .wdata (cmd),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state         <= IDLE;
            xfer          <= '0;
            tcnt          <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (pop) begin
                        xfer   <= load;
                        psel_o <= 1'b1;
                        state  <= SETUP;
                    end
                SETUP: begin
                    penable_o <= 1'b1;
                    tcnt      <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    tcnt <= tcnt + TW'(1);
                    if (pready_i || tcnt == TLIM) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_err_o     <= !pready_i || pslverr_i;
                        rsp_timeout_o <= !pready_i;
                        rsp_rdata_o   <= (pready_i && !xfer.write) ? prdata_i : '0;
                        state         <= RESP;
                    end
                end
                RESP:
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        if (pop) begin
                            xfer   <= load;
                            psel_o <= 1'b1;
                            state  <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                default: state <= IDLE;
            endcase
        end

endmodule
